icache_direct_mapped: RTL

//  Direct-mapped, read-only instruction cache between the CPU fetch port and the slow instruction memory.

---
 rtl/icache_direct_mapped.sv | 131 +++++++++++++
 1 files changed

// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache.
// Serves hits combinationally from PC. On a miss it stalls the CPU,
// fetches a 4-word block from instruction memory, installs it, and then
// serves the instruction from the cache.
module icache_direct_mapped #(
    parameter int ADDR_BITS  = 10,
    parameter int INDEX_BITS = 3
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          PC,
    output logic [31:0]          INSTRUCTION,
    output logic                 BUSYWAIT,
    output logic                 MEM_READ,
    output logic [ADDR_BITS-5:0] MEM_ADDRESS,
    input  logic [127:0]         MEM_READDATA,
    input  logic                 MEM_BUSYWAIT
);

    localparam int TAG_BITS      = ADDR_BITS - 4 - INDEX_BITS;
    localparam int BLK_ADDR_BITS = ADDR_BITS - 4;
    localparam int NUM_BLOCKS    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_UPDATE
    } state_e;

    state_e                    state_q, state_d;
    logic [BLK_ADDR_BITS-1:0]  miss_addr_q, miss_addr_d;
    logic [NUM_BLOCKS-1:0]     valid_q;
    logic [TAG_BITS-1:0]       tag_q  [NUM_BLOCKS];
    logic [3:0][31:0]          data_q [NUM_BLOCKS];

    logic [1:0]                pc_offset;
    logic [INDEX_BITS-1:0]     pc_index;
    logic [TAG_BITS-1:0]       pc_tag;
    logic [INDEX_BITS-1:0]     miss_index;
    logic [TAG_BITS-1:0]       miss_tag;
    logic                      hit;
    logic                      fill_en;
    logic                      busy;
    logic                      unused_pc;

    // Address split; the upper PC bits and the byte offset within a word are ignored.
    assign pc_offset  = PC[3:2];
    assign pc_index   = PC[INDEX_BITS+3:4];
    assign pc_tag     = PC[ADDR_BITS-1:INDEX_BITS+4];
    assign unused_pc  = ^{PC[31:ADDR_BITS], PC[1:0]};

    assign miss_index = miss_addr_q[INDEX_BITS-1:0];
    assign miss_tag   = miss_addr_q[BLK_ADDR_BITS-1:INDEX_BITS];

    assign hit        = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);

    // The block is installed on the cycle memory reports completion; the
    // fill always targets the latched miss address, never the live PC.
    assign fill_en    = (state_q == S_FETCH) && !MEM_BUSYWAIT;

    assign INSTRUCTION = data_q[pc_index][pc_offset];
    assign MEM_ADDRESS = miss_addr_q;
    // Reset forces the stall low even though every lookup misses while valid bits are clear.
    assign BUSYWAIT    = busy & RESET;

    // State and miss-address registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q     <= S_IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    // Next-state logic and FSM-driven outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, otherwise
        // paths that skip an assignment would infer latches.
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        busy        = 1'b0;
        MEM_READ    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = ~hit;
                if (!hit) begin
                    miss_addr_d = {pc_tag, pc_index};
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                busy     = 1'b1;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                busy    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Valid bits: cleared by reset, set when a block is installed.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[miss_index] <= 1'b1;
        end
    end

    // Tag and data storage, written only by a completed fill.
    always_ff @(posedge CLK) begin
        // NOTE: the tag/data arrays are deliberately not reset; the valid
        // bits alone decide whether their contents are meaningful.
        if (fill_en) begin
            tag_q[miss_index]  <= miss_tag;
            data_q[miss_index] <= MEM_READDATA;
        end
    end

endmodule
